// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: shared encodings and default widths for the data memory arbiter
package data_memory_arbiter_pkg;
    typedef enum logic [1:0] {ARB, LOCKED_A, LOCKED_B} arb_state_e;
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/data_memory_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker with a forced owner override, one-hot grant out
module rr_pick2 (
    input  logic       ptr,
    input  logic [1:0] req,
    input  logic       force_en,
    input  logic       force_id,
    output logic [1:0] gnt
);
    // forced owner wins alone; otherwise pointer breaks ties and a lone request is granted
    always_comb begin
        gnt = force_en ? (req & (2'b01 << force_id)) : (&req ? (2'b01 << ptr) : req);
    end
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares a single-port data memory between requesters A and B
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = 8,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic              a_lock,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              mem_writeEnable,
    input  logic [DATA_W-1:0] mem_dataOut
);
    localparam int CW = $clog2(LOCK_MAX);
    localparam logic [CW-1:0] CNT_EXIT = CW'(LOCK_MAX - 2);

    arb_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rpend_q, rpend_d;
    logic              owner_q, owner_d;
    logic [1:0]        req, gnt;
    logic              lock_id, force_en, other_req, any_gnt, gid, g_lock, g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    // requests are masked during reset so nothing is granted or written
    always_comb begin
        req       = reset ? 2'b00 : {b_req, a_req};
        lock_id   = (state_q == LOCKED_B);
        force_en  = (state_q != ARB) && req[lock_id];
        other_req = req[~lock_id];
        any_gnt   = |gnt;
        gid       = gnt[1];
        g_lock    = gid ? b_lock : a_lock;
        g_we      = gid ? b_we : a_we;
        g_addr    = gid ? b_addr : a_addr;
        g_wdata   = gid ? b_wdata : a_wdata;
    end

    rr_pick2 u_pick (
        .ptr      (ptr_q),
        .req      (req),
        .force_en (force_en),
        .force_id (lock_id),
        .gnt      (gnt)
    );

    // memory port follows the grant and holds the last granted address/data when idle
    always_comb begin
        a_gnt           = gnt[0];
        b_gnt           = gnt[1];
        mem_writeEnable = any_gnt && g_we;
        mem_address     = reset ? '0 : (any_gnt ? g_addr : addr_q);
        mem_dataIn      = reset ? '0 : (any_gnt ? g_wdata : wdata_q);
        a_rvalid        = !reset && rpend_q && (owner_q == REQ_A);
        b_rvalid        = !reset && rpend_q && (owner_q == REQ_B);
        a_rdata         = a_rvalid ? mem_dataOut : '0;
        b_rdata         = b_rvalid ? mem_dataOut : '0;
    end

    // lock holding with starvation bound, round-robin pointer and read-return tracking
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        addr_d  = any_gnt ? g_addr : addr_q;
        wdata_d = any_gnt ? g_wdata : wdata_q;
        rpend_d = any_gnt && !g_we;
        owner_d = any_gnt ? gid : owner_q;
        if (force_en) begin
            cnt_d = other_req ? cnt_q + 1'b1 : cnt_q;
            if (other_req && cnt_q == CNT_EXIT) begin
                state_d = ARB;
                ptr_d   = ~lock_id;
            end else if (!g_lock) begin
                state_d = ARB;
            end
        end else begin
            ptr_d   = &req ? ~ptr_q : ptr_q;
            state_d = (any_gnt && g_lock) ? (gid ? LOCKED_B : LOCKED_A) : ARB;
            cnt_d   = (any_gnt && g_lock) ? '0 : cnt_q;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            ptr_q   <= REQ_A;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rpend_q <= 1'b0;
            owner_q <= REQ_A;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rpend_q <= rpend_d;
            owner_q <= owner_d;
        end
    end
endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single-port data memory between two requesters: port A (CPU load/store unit) and port B (DMA/debug loader). Each cycle it grants at most one request using round-robin priority, drives the memory's address/dataIn/writeEnable, and returns read data to the granted requester with a fixed one-cycle latency. An optional lock lets one requester issue back-to-back transactions, bounded by a starvation counter. It sits between the requesters and the datamemory instance, which has synchronous write and one-cycle registered read.

## Interface
- LOCK_MAX, default 8: maximum consecutive grants a locking requester keeps while the other requester is waiting.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.

- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a_req / b_req  input  1  request valid; held with its attributes until the matching gnt.
- a_we / b_we  input  1  1 = write, 0 = read.
- a_lock / b_lock  input  1  keep the grant on the next cycle if still requesting.
- a_addr / b_addr  input  ADDR_W  word address.
- a_wdata / b_wdata  input  DATA_W  write data.
- a_gnt / b_gnt  output  1  combinational; transaction accepted this cycle.
- a_rvalid / b_rvalid  output  1  registered; read data valid this cycle.
- a_rdata / b_rdata  output  DATA_W  read data, qualified by rvalid.
- mem_address  output  ADDR_W  to memory address.
- mem_dataIn  output  DATA_W  to memory dataIn.
- mem_writeEnable  output  1  to memory writeEnable.
- mem_dataOut  input  DATA_W  from memory dataOut; valid one cycle after the address is presented.

## Operation
- States: ARB and LOCKED_A / LOCKED_B. Reset state is ARB. The round-robin pointer resets to A. The lock counter resets to 0.
- ARB with one requester active: grant it.
- ARB with both requesting: grant the pointer side. The pointer then flips to the other side.
- ARB: a granted request with lock=1 moves to LOCKED_x and clears the counter.
- LOCKED_x with x_req=1: grant x unconditionally.
  - If the other side is also requesting, increment the counter. Otherwise leave it unchanged.
- Leave LOCKED_x for ARB after a grant when:
  - x_lock=0 on the granted transaction, or
  - the counter reaches LOCK_MAX-1 with the other side requesting. The pointer then points to the other side.
- LOCKED_x with x_req=0: no grant that cycle. Return to ARB and evaluate normally in the same cycle, so the other side may be granted.
- Granted transaction drives the memory port:
  - mem_address = x_addr.
  - mem_dataIn = x_wdata.
  - mem_writeEnable = x_we.
- No grant: mem_writeEnable=0. mem_address and mem_dataIn keep their last granted values.
- Read grant sets a one-bit owner register and a pending flag. The next cycle, x_rvalid=1 and x_rdata = mem_dataOut.
- The non-owner's rdata is 0. A read can be granted every cycle, fully pipelined.
- Write grant produces no rvalid.

## Timing
- Grant is combinational from req/lock/state/pointer in the same cycle.
- The write takes effect at the rising edge ending the grant cycle.
- Read latency is exactly 1 cycle from grant to rvalid.
- A read granted in the cycle after a write to the same address returns the new data.
- Reset values: gnt 0, rvalid 0, rdata 0, mem_writeEnable 0, mem_address 0, mem_dataIn 0.
- Reset asserted mid-operation:
  - A pending rvalid is dropped, not delivered.
  - The lock is released and the pointer returns to A.
  - No memory write occurs in any reset cycle.
- Simultaneous first requests after reset: A wins.
- Lock counter width is clog2(LOCK_MAX). It never wraps: saturation forces the exit.

## Structure
- Shared package holds:
  - the state encoding (ARB, LOCKED_A, LOCKED_B),
  - the requester ID constants (REQ_A=0, REQ_B=1),
  - the default ADDR_W/DATA_W, matching the datamemory instance.
- One natural sub-module, rr_pick2: a combinational two-way round-robin picker taking pointer, reqs, and a forced-owner input, producing one-hot grants.
- Everything else lives in data_memory_arbiter.

## Test plan
- Single requester: A writes 42 to addr 0, then reads addr 0.
  - a_gnt=1 in both cycles; a_rvalid=1 with a_rdata=42 one cycle after the read grant.
  - b_rvalid stays 0.
- Contention, no lock: A and B both read continuously for 4 cycles.
  - Grants alternate A,B,A,B.
  - rvalid follows each grant by 1 cycle, on the matching port.
- Lock with starvation, LOCK_MAX=4: A holds lock=1 and req=1 while B requests.
  - A is granted exactly 4 consecutive times, then B is granted.
  - The pointer then favours A again.
- Write/read ordering: B writes 48 to addr 1 while A continuously requests a read of addr 0 (preloaded 42).
  - A reads return 42.
  - A subsequent read of addr 1 returns 48.
  - No write occurs when writeEnable=0 requests are granted.
- Reset mid-read: grant an A read, then assert reset in the next cycle.
  - a_rvalid=0 during reset.
  - After release, simultaneous A/B requests grant A first.
  - mem_writeEnable stays 0 throughout reset.
